// File: rtl/frame_buffer_dp.sv
// frame_buffer_dp: simple-dual-port pixel frame buffer with streaming write port, pipelined read port and clear FSM
module frame_buffer_dp #(
    parameter int                    DATA_WIDTH     = 24,
    parameter int                    ADDR_BITS      = 16,
    parameter int                    IMG_WIDTH      = 220,
    parameter int                    IMG_HEIGHT     = 220,
    parameter int                    READ_LATENCY   = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear_start,
    output logic                  busy,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_sof,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_BITS-1:0]  wr_addr,
    output logic                  frame_done,
    input  logic                  rd_req,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int IA = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(PIXELS - 1);
    localparam logic [ADDR_BITS-1:0] ONE = ADDR_BITS'(1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                state, state_nx;
    logic [ADDR_BITS-1:0]  clr_addr, wr_tgt;
    logic [IA-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0] mem_wd, d1;
    logic                  wr_acc, rd_acc, rd_in, mem_we, v1;
    logic [DATA_WIDTH-1:0] mem [PIXELS];

    assign busy     = (state == S_CLEAR);
    assign wr_acc   = wr_valid & wr_ready;
    assign wr_tgt   = wr_sof ? '0 : wr_addr;
    assign rd_acc   = rd_req & ~busy;
    assign rd_in    = (rd_addr <= LAST);
    assign mem_we   = busy | wr_acc;
    assign mem_addr = busy ? clr_addr[IA-1:0] : wr_tgt[IA-1:0];
    assign mem_wd   = busy ? CLEAR_VALUE : wr_data;

    // clear runs to the last pixel then hands over to RUN; RUN leaves only on a clear request
    always_comb begin
        state_nx = (state == S_CLEAR) ? ((clr_addr == LAST) ? S_RUN : S_CLEAR)
                                      : (clear_start ? S_CLEAR : S_RUN);
    end

    // control registers: FSM state, clear counter, write pointer, ready and frame pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            clr_addr   <= '0;
            wr_addr    <= '0;
            wr_ready   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            clr_addr   <= (busy && clr_addr != LAST) ? clr_addr + ONE : '0;
            wr_ready   <= (state == S_RUN) && !clear_start;
            wr_addr    <= busy ? '0 : wr_acc ? ((wr_tgt == LAST) ? '0 : wr_tgt + ONE) : wr_addr;
            frame_done <= wr_acc && (wr_tgt == LAST);
        end
    end

    // single RAM write port shared by the clear FSM and the pixel stream
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wd;
    end

    // first read stage: read-first RAM access, out-of-range addresses return the clear value
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) d1 <= rd_in ? mem[rd_addr[IA-1:0]] : CLEAR_VALUE;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  v2;
        logic [DATA_WIDTH-1:0] d2;
        // optional output register; data only moves when a result is present
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) d2 <= d1;
            end
        end
        assign rd_valid = v2;
        assign rd_data  = d2;
    end else begin : g_lat1
        assign rd_valid = v1;
        assign rd_data  = d1;
    end
endmodule
